// File: rtl/aia_pkg.sv
// -----------------------------------------------------------------------------
// aia_pkg
// Shared definitions for the AIA interrupt-file logic of one hart.
//   - default file / source counts (mirrors of the core configuration)
//   - file-index constants for the M, S and first VS interrupt file
//   - csr_op_e: operations a CSR indirect access can apply to one identity
// -----------------------------------------------------------------------------
package aia_pkg;

  // Core configuration defaults: M + S + one VS file, 30 identities per file
  localparam int CFG_NR_INTP_FILES = 3;
  localparam int CFG_NR_SOURCES    = 30;
  localparam int CFG_STARVE_LIMIT  = 4;

  // Fixed placement of the interrupt files inside the file arrays
  localparam int M_FILE       = 0;
  localparam int S_FILE       = 1;
  localparam int VS_FILE_BASE = 2;

  // Encodings 5..7 are not listed and fall back to READ behaviour
  typedef enum logic [2:0] {
    CSR_READ     = 3'd0,
    CSR_SET_PEND = 3'd1,
    CSR_CLR_PEND = 3'd2,
    CSR_SET_EN   = 3'd3,
    CSR_CLR_EN   = 3'd4
  } csr_op_e;

endpackage

// File: rtl/aia_top_prio_enc.sv
// -----------------------------------------------------------------------------
// aia_top_prio_enc
// Lowest-set-index encoder used to find the top interrupt of one file.
// Bit 0 is identity "none" and never wins.
// Ports:
//   bits_i  in   NR_SOURCES    pending & enable vector of one file
//   id_o    out  NR_SOURCES_W  lowest set index >= 1, or 0 when none is set
// -----------------------------------------------------------------------------
module aia_top_prio_enc #(
  parameter int NR_SOURCES   = 30,
  parameter int NR_SOURCES_W = $clog2(NR_SOURCES)
) (
  input  logic [NR_SOURCES-1:0]   bits_i,
  output logic [NR_SOURCES_W-1:0] id_o
);

  logic unused_bit0;
  assign unused_bit0 = bits_i[0];

  // Scan from the top down so the lowest set identity is the last one written
  always_comb begin
    id_o = '0;
    for (int i = NR_SOURCES - 1; i >= 1; i--) begin
      if (bits_i[i]) id_o = NR_SOURCES_W'(i);
    end
  end

endmodule

// File: rtl/aia_intp_file_arbiter.sv
// -----------------------------------------------------------------------------
// aia_intp_file_arbiter
// Holds pending/enable bits of all interrupt files of one hart and arbitrates
// the single update slot per cycle between MSI writes, CSR accesses and claims.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   msi_valid_i/ready_o          MSI write handshake; msi_file_i, msi_id_i
//   csr_valid_i/ready_o          CSR access handshake; csr_file_i, csr_op_i, csr_id_i
//   csr_rvalid_o, csr_rdata_o    one-cycle CSR response {enable,pending} pre-update
//   claim_valid_i/ready_o        claim handshake; claim_file_i
//   claim_rvalid_o, claim_id_o   one-cycle claim response (0 = nothing claimed)
//   topid_o                      registered top identity, file f at [f*W +: W]
//   eip_o                        registered external-interrupt-pending per file
// -----------------------------------------------------------------------------
module aia_intp_file_arbiter
  import aia_pkg::*;
#(
  parameter int NR_INTP_FILES = CFG_NR_INTP_FILES,
  parameter int NR_SOURCES    = CFG_NR_SOURCES,
  parameter int NR_SOURCES_W  = $clog2(NR_SOURCES),
  parameter int STARVE_LIMIT  = CFG_STARVE_LIMIT,
  localparam int FILE_W       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   msi_valid_i,
  output logic                                   msi_ready_o,
  input  logic [FILE_W-1:0]                      msi_file_i,
  input  logic [NR_SOURCES_W-1:0]                msi_id_i,
  input  logic                                   csr_valid_i,
  output logic                                   csr_ready_o,
  input  logic [FILE_W-1:0]                      csr_file_i,
  input  logic [2:0]                             csr_op_i,
  input  logic [NR_SOURCES_W-1:0]                csr_id_i,
  output logic                                   csr_rvalid_o,
  output logic [1:0]                             csr_rdata_o,
  input  logic                                   claim_valid_i,
  output logic                                   claim_ready_o,
  input  logic [FILE_W-1:0]                      claim_file_i,
  output logic                                   claim_rvalid_o,
  output logic [NR_SOURCES_W-1:0]                claim_id_o,
  output logic [NR_INTP_FILES*NR_SOURCES_W-1:0]  topid_o,
  output logic [NR_INTP_FILES-1:0]               eip_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [NR_INTP_FILES-1:0][NR_SOURCES-1:0]   pend_q, pend_d, en_q, en_d;
  logic [NR_INTP_FILES-1:0][NR_SOURCES_W-1:0] top_comb, topid_q;
  logic [NR_INTP_FILES-1:0]                   eip_q;
  logic [STARVE_W-1:0]                        starve_q, starve_d;
  logic                                       csr_rvalid_q, claim_rvalid_q;
  logic [1:0]                                 csr_rdata_q, csr_rdata_d;
  logic [NR_SOURCES_W-1:0]                    claim_id_q, claim_id_d, claim_top;
  logic                                       msi_gnt, csr_gnt, claim_gnt, starved;
  logic                                       msi_ok, csr_ok, claim_ok;

  // One encoder per file over the currently pending-and-enabled identities
  for (genvar f = 0; f < NR_INTP_FILES; f++) begin : g_enc
    aia_top_prio_enc #(
      .NR_SOURCES  (NR_SOURCES),
      .NR_SOURCES_W(NR_SOURCES_W)
    ) u_enc (
      .bits_i(pend_q[f] & en_q[f]),
      .id_o  (top_comb[f])
    );
  end

  // Identity 0 is never a real source, so it is treated like out-of-range
  assign starved  = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign msi_ok   = (32'(msi_file_i) < NR_INTP_FILES) && (msi_id_i != '0) &&
                    (32'(msi_id_i) < NR_SOURCES);
  assign csr_ok   = (32'(csr_file_i) < NR_INTP_FILES) && (csr_id_i != '0) &&
                    (32'(csr_id_i) < NR_SOURCES);
  assign claim_ok = (32'(claim_file_i) < NR_INTP_FILES);

  // Fixed priority claim > CSR > MSI, except a starved MSI jumps the queue
  always_comb begin
    msi_gnt   = 1'b0;
    csr_gnt   = 1'b0;
    claim_gnt = 1'b0;
    if (!rst_i) begin
      if (msi_valid_i && starved)  msi_gnt   = 1'b1;
      else if (claim_valid_i)      claim_gnt = 1'b1;
      else if (csr_valid_i)        csr_gnt   = 1'b1;
      else if (msi_valid_i)        msi_gnt   = 1'b1;
    end
  end

  assign msi_ready_o   = msi_gnt;
  assign csr_ready_o   = csr_gnt;
  assign claim_ready_o = claim_gnt;

  always_comb begin
    claim_top = '0;
    if (claim_ok) claim_top = top_comb[claim_file_i];
  end

  // Apply the single granted update; responses capture pre-update state
  always_comb begin
    pend_d      = pend_q;
    en_d        = en_q;
    csr_rdata_d = '0;
    claim_id_d  = '0;
    if (msi_gnt && msi_ok) pend_d[msi_file_i][msi_id_i] = 1'b1;
    if (csr_gnt && csr_ok) begin
      csr_rdata_d = {en_q[csr_file_i][csr_id_i], pend_q[csr_file_i][csr_id_i]};
      case (csr_op_e'(csr_op_i))
        CSR_SET_PEND: pend_d[csr_file_i][csr_id_i] = 1'b1;
        CSR_CLR_PEND: pend_d[csr_file_i][csr_id_i] = 1'b0;
        CSR_SET_EN:   en_d[csr_file_i][csr_id_i]   = 1'b1;
        CSR_CLR_EN:   en_d[csr_file_i][csr_id_i]   = 1'b0;
        default:      ;
      endcase
    end
    if (claim_gnt) begin
      claim_id_d = claim_top;
      if (claim_top != '0) pend_d[claim_file_i][claim_top] = 1'b0;
    end
  end

  // Starve counter tracks consecutive cycles an MSI waited without a grant
  always_comb begin
    starve_d = starve_q;
    if (!msi_valid_i || msi_gnt) starve_d = '0;
    else if (!starved)           starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q         <= '0;
      en_q           <= '0;
      topid_q        <= '0;
      eip_q          <= '0;
      starve_q       <= '0;
      csr_rvalid_q   <= 1'b0;
      csr_rdata_q    <= '0;
      claim_rvalid_q <= 1'b0;
      claim_id_q     <= '0;
    end else begin
      pend_q         <= pend_d;
      en_q           <= en_d;
      starve_q       <= starve_d;
      csr_rvalid_q   <= csr_gnt;
      csr_rdata_q    <= csr_rdata_d;
      claim_rvalid_q <= claim_gnt;
      claim_id_q     <= claim_id_d;
      for (int f = 0; f < NR_INTP_FILES; f++) begin
        topid_q[f] <= top_comb[f];
        eip_q[f]   <= (top_comb[f] != '0);
      end
    end
  end

  assign csr_rvalid_o   = csr_rvalid_q;
  assign csr_rdata_o    = csr_rdata_q;
  assign claim_rvalid_o = claim_rvalid_q;
  assign claim_id_o     = claim_id_q;
  assign topid_o        = topid_q;
  assign eip_o          = eip_q;

endmodule

// File: tb/tb_aia_intp_file_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aia_intp_file_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the interrupt files kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_aia_intp_file_arbiter;

  localparam int NF  = 3;
  localparam int NS  = 30;
  localparam int W   = 5;
  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            msi_valid_i = 1'b0, csr_valid_i = 1'b0, claim_valid_i = 1'b0;
  logic            msi_ready_o, csr_ready_o, claim_ready_o;
  logic [1:0]      msi_file_i = '0, csr_file_i = '0, claim_file_i = '0;
  logic [4:0]      msi_id_i = '0, csr_id_i = '0;
  logic [2:0]      csr_op_i = '0;
  logic            csr_rvalid_o, claim_rvalid_o;
  logic [1:0]      csr_rdata_o;
  logic [4:0]      claim_id_o;
  logic [NF*W-1:0] topid_o;
  logic [NF-1:0]   eip_o;

  aia_intp_file_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .msi_valid_i(msi_valid_i), .msi_ready_o(msi_ready_o),
    .msi_file_i(msi_file_i), .msi_id_i(msi_id_i),
    .csr_valid_i(csr_valid_i), .csr_ready_o(csr_ready_o),
    .csr_file_i(csr_file_i), .csr_op_i(csr_op_i), .csr_id_i(csr_id_i),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o),
    .claim_valid_i(claim_valid_i), .claim_ready_o(claim_ready_o),
    .claim_file_i(claim_file_i),
    .claim_rvalid_o(claim_rvalid_o), .claim_id_o(claim_id_o),
    .topid_o(topid_o), .eip_o(eip_o)
  );

  always #5 clk = ~clk;

  // Request holders: a request stays up until the model sees it granted
  logic       rstReq = 1'b1;
  logic       mV = 1'b0, cV = 1'b0, lV = 1'b0;
  logic [1:0] mF = '0, cF = '0, lF = '0;
  logic [4:0] mId = '0, cId = '0;
  logic [2:0] cOp = '0;
  logic [2:0] lastReady;

  // Behavioural model of the files and the expected registered outputs
  bit         modPend[NF][NS];
  bit         modEn[NF][NS];
  int         modStarve = 0;
  logic       expCsrRv, expClRv;
  logic [1:0] expCsrRd;
  logic [4:0] expClId;
  logic [NF*W-1:0] expTop;
  logic [NF-1:0]   expEip;

  int total = 0;
  int bad   = 0;

  function automatic int modelTop(int f);
    if (f < 0 || f >= NF) return 0;
    for (int i = 1; i < NS; i++)
      if (modPend[f][i] && modEn[f][i]) return i;
    return 0;
  endfunction

  function automatic bit idOk(int f, int id);
    return (f < NF) && (id != 0) && (id < NS);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One full cycle: drive, check grant, advance the model, check registered outputs
  task automatic applyStimulus();
    int g;
    int t;
    @(negedge clk);
    rst           = rstReq;
    msi_valid_i   = mV;  msi_file_i = mF;  msi_id_i = mId;
    csr_valid_i   = cV;  csr_file_i = cF;  csr_op_i = cOp;  csr_id_i = cId;
    claim_valid_i = lV;  claim_file_i = lF;
    #1;
    g = 0;
    if (!rstReq) begin
      if (mV && modStarve == LIM) g = 1;
      else if (lV)                g = 3;
      else if (cV)                g = 2;
      else if (mV)                g = 1;
    end
    checkOutput("msi_ready",   32'(msi_ready_o),   32'(g == 1));
    checkOutput("csr_ready",   32'(csr_ready_o),   32'(g == 2));
    checkOutput("claim_ready", 32'(claim_ready_o), 32'(g == 3));
    lastReady = {claim_ready_o, csr_ready_o, msi_ready_o};

    if (rstReq) begin
      for (int f = 0; f < NF; f++)
        for (int i = 0; i < NS; i++) begin
          modPend[f][i] = 1'b0;
          modEn[f][i]   = 1'b0;
        end
      modStarve = 0;
      expTop = '0; expEip = '0;
      expCsrRv = 1'b0; expCsrRd = '0; expClRv = 1'b0; expClId = '0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        expTop[f*W +: W] = W'(modelTop(f));
        expEip[f]        = (modelTop(f) != 0);
      end
      expCsrRv = (g == 2); expCsrRd = '0;
      expClRv  = (g == 3); expClId  = '0;
      if (mV && g != 1) modStarve = (modStarve < LIM) ? modStarve + 1 : LIM;
      else              modStarve = 0;
      if (g == 1 && idOk(int'(mF), int'(mId)))
        modPend[mF][mId] = 1'b1;
      if (g == 2 && idOk(int'(cF), int'(cId))) begin
        expCsrRd = {modEn[cF][cId], modPend[cF][cId]};
        case (cOp)
          3'd1: modPend[cF][cId] = 1'b1;
          3'd2: modPend[cF][cId] = 1'b0;
          3'd3: modEn[cF][cId]   = 1'b1;
          3'd4: modEn[cF][cId]   = 1'b0;
          default: ;
        endcase
      end
      if (g == 3) begin
        t = modelTop(int'(lF));
        expClId = W'(t);
        if (t != 0) modPend[lF][t] = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    checkOutput("csr_rvalid",   32'(csr_rvalid_o),   32'(expCsrRv));
    checkOutput("csr_rdata",    32'(csr_rdata_o),    32'(expCsrRd));
    checkOutput("claim_rvalid", 32'(claim_rvalid_o), 32'(expClRv));
    checkOutput("claim_id",     32'(claim_id_o),     32'(expClId));
    checkOutput("topid",        32'(topid_o),        32'(expTop));
    checkOutput("eip",          32'(eip_o),          32'(expEip));
    if (g == 1) mV = 1'b0;
    if (g == 2) cV = 1'b0;
    if (g == 3) lV = 1'b0;
  endtask

  task automatic idle();
    applyStimulus();
  endtask

  task automatic doMsi(input int f, input int id);
    mV = 1'b1; mF = 2'(f); mId = 5'(id);
    for (int k = 0; k < 10 && mV; k++) applyStimulus();
    if (mV) begin checkOutput("msi_timeout", 32'(1), 32'(0)); mV = 1'b0; end
  endtask

  task automatic doCsr(input int op, input int f, input int id);
    cV = 1'b1; cOp = 3'(op); cF = 2'(f); cId = 5'(id);
    for (int k = 0; k < 10 && cV; k++) applyStimulus();
    if (cV) begin checkOutput("csr_timeout", 32'(1), 32'(0)); cV = 1'b0; end
  endtask

  task automatic doClaim(input int f);
    lV = 1'b1; lF = 2'(f);
    for (int k = 0; k < 10 && lV; k++) applyStimulus();
    if (lV) begin checkOutput("claim_timeout", 32'(1), 32'(0)); lV = 1'b0; end
  endtask

  initial begin
    int stalls;

    // Reset with requests raised: nothing may be granted
    rstReq = 1'b1; mV = 1'b1; cV = 1'b1; lV = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("lit_reset_ready", 32'(lastReady), 32'(0));
    mV = 1'b0; cV = 1'b0; lV = 1'b0; rstReq = 1'b0;
    idle();

    // Enable then deliver id 5 to file 1
    doCsr(3, 1, 5);
    doMsi(1, 5);
    checkOutput("lit_top1_before", 32'(topid_o[9:5]), 32'(0));
    idle();
    checkOutput("lit_top1", 32'(topid_o[9:5]), 32'(5));
    checkOutput("lit_eip1", 32'(eip_o), 32'(3'b010));

    // Two pending ids in file 0, claimed lowest first
    doCsr(3, 0, 7);
    doCsr(3, 0, 3);
    doMsi(0, 7);
    doMsi(0, 3);
    idle();
    doClaim(0);
    checkOutput("lit_claim1", 32'(claim_id_o), 32'(3));
    checkOutput("lit_claim1_rv", 32'(claim_rvalid_o), 32'(1));
    idle();
    checkOutput("lit_top0_after", 32'(topid_o[4:0]), 32'(7));
    doClaim(0);
    checkOutput("lit_claim2", 32'(claim_id_o), 32'(7));
    doClaim(0);
    checkOutput("lit_claim3", 32'(claim_id_o), 32'(0));
    checkOutput("lit_eip0_clear", 32'(eip_o[0]), 32'(0));

    // All three requesters at once
    lV = 1'b1; lF = 2'd1;
    cV = 1'b1; cOp = 3'd0; cF = 2'd0; cId = 5'd1;
    mV = 1'b1; mF = 2'd2; mId = 5'd4;
    applyStimulus();
    checkOutput("lit_order1", 32'(lastReady), 32'(3'b100));
    applyStimulus();
    checkOutput("lit_order2", 32'(lastReady), 32'(3'b010));
    applyStimulus();
    checkOutput("lit_order3", 32'(lastReady), 32'(3'b001));

    // CSR hogging the slot until MSI is starved
    mV = 1'b1; mF = 2'd2; mId = 5'd9;
    stalls = 0;
    for (int k = 0; k < 10 && mV; k++) begin
      cV = 1'b1; cOp = 3'd0; cF = 2'd0; cId = 5'd2;
      applyStimulus();
      if (!lastReady[0]) stalls++;
    end
    checkOutput("lit_starve", 32'(stalls), 32'(4));
    idle();

    // Out-of-range requests
    doMsi(0, 0);
    doMsi(0, 30);
    doMsi(3, 5);
    doCsr(0, 3, 5);
    checkOutput("lit_csr_oob", 32'(csr_rdata_o), 32'(0));
    doCsr(6, 0, 3);
    checkOutput("lit_csr_op6", 32'(csr_rdata_o), 32'(2'b10));

    // Reset while a CSR response is outstanding
    doMsi(0, 3);
    doCsr(0, 0, 3);
    rstReq = 1'b1; mV = 1'b1; cV = 1'b1; lV = 1'b1;
    applyStimulus();
    checkOutput("lit_rst_ready", 32'(lastReady), 32'(0));
    checkOutput("lit_rst_rvalid", 32'(csr_rvalid_o), 32'(0));
    checkOutput("lit_rst_topid", 32'(topid_o), 32'(0));
    checkOutput("lit_rst_eip", 32'(eip_o), 32'(0));
    rstReq = 1'b0; mV = 1'b0; cV = 1'b0; lV = 1'b0;
    idle();

    // Randomized traffic honouring hold-until-ready
    for (int n = 0; n < 3000; n++) begin
      if (!mV && $urandom_range(0, 1) == 0) begin
        mV  = 1'b1;
        mF  = 2'($urandom_range(0, 3));
        mId = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 8));
      end
      if (!cV && $urandom_range(0, 2) == 0) begin
        cV  = 1'b1;
        cF  = 2'($urandom_range(0, 3));
        cOp = 3'($urandom_range(0, 7));
        cId = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'($urandom_range(1, 8));
      end
      if (!lV && $urandom_range(0, 3) == 0) begin
        lV = 1'b1;
        lF = 2'($urandom_range(0, 3));
      end
      rstReq = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    rstReq = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aia_intp_file_arbiter.md
Name: aia_intp_file_arbiter

Overview:
- Holds the pending and enable bit arrays for all AIA interrupt files (M, S and VS files) of one hart.
- Arbitrates the single update slot per cycle between three requesters: incoming MSI writes, CSR indirect accesses and interrupt claims.
- Publishes a registered top interrupt identity and an external-interrupt-pending flag per file.
- Sits between the bus-side MSI decoder, the CSR file and the interrupt/trap logic.

Parameters:
- NR_INTP_FILES, 3, number of interrupt files (2 + number of VS files).
- NR_SOURCES, 30, identities per file. Identity 0 means "none". Valid identities are 1..NR_SOURCES-1.
- NR_SOURCES_W, $clog2(NR_SOURCES), identity width.
- STARVE_LIMIT, 4, number of consecutive stalled MSI cycles before MSI is promoted to top priority.
- FILE_W (derived), max(1,$clog2(NR_INTP_FILES)), file index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- msi_valid_i  in  1  MSI write request
- msi_ready_o  out  1  MSI granted this cycle
- msi_file_i  in  FILE_W  target file
- msi_id_i  in  NR_SOURCES_W  identity to set pending
- csr_valid_i  in  1  CSR access request
- csr_ready_o  out  1  CSR granted this cycle
- csr_file_i  in  FILE_W  target file
- csr_op_i  in  3  0 READ, 1 SET_PEND, 2 CLR_PEND, 3 SET_EN, 4 CLR_EN; 5-7 treated as READ
- csr_id_i  in  NR_SOURCES_W  identity
- csr_rvalid_o  out  1  CSR response valid
- csr_rdata_o  out  2  {enable,pending} before update
- claim_valid_i  in  1  claim request
- claim_ready_o  out  1  claim granted
- claim_file_i  in  FILE_W  file to claim from
- claim_rvalid_o  out  1  claim response valid
- claim_id_o  out  NR_SOURCES_W  claimed identity (0 = none)
- topid_o  out  NR_INTP_FILES*NR_SOURCES_W  registered top identity per file; file f at bits [f*W +: W]
- eip_o  out  NR_INTP_FILES  registered, topid of file f != 0

Behaviour:
- Reset: with rst_i high at a clock edge, all pending bits, enable bits, topid_o, eip_o, csr_rvalid_o, csr_rdata_o, claim_rvalid_o, claim_id_o and the starve counter are cleared. While rst_i is high all *_ready_o are 0. In-flight responses are dropped.
- Grant: at most one ready_o high per cycle. It is combinational from the valids. Requesters must not make valid depend on ready.
- Priority: MSI if starve_cnt == STARVE_LIMIT; otherwise claim > CSR > MSI.
- Transfer: a request transfers when valid && ready in the same cycle. Requester fields must hold stable while valid && !ready.
- Starve counter: increments, saturating at STARVE_LIMIT, each cycle msi_valid_i && !msi_ready_o. Clears on MSI grant or when msi_valid_i is low.
- Top identity: per-file top = lowest identity i ≥ 1 with pending && enable, else 0. It is computed combinationally from current state. topid_o and eip_o register it with 1-cycle latency after any update.
- MSI grant: sets pending[file][id] at the clock edge. id 0, id ≥ NR_SOURCES or file ≥ NR_INTP_FILES is accepted and silently dropped.
- CSR grant: the op is applied at the edge. csr_rvalid_o is 1 in the next cycle for exactly one cycle. csr_rdata_o holds the pre-update bits. An out-of-range file/id returns 0 with no update.
- Claim grant: returns the combinational top of claim_file_i at the grant cycle. This reflects all updates through the previous edge. The pending bit of that identity is cleared at the edge. claim_rvalid_o and claim_id_o are valid the next cycle for exactly one cycle. A top of 0 returns 0 with no state change.
- Hazards: only one update per cycle, so there are no same-bit conflicts. The next requester sees the previous update.
- Idle: response outputs are 0 when the corresponding rvalid is 0.

Decomposition:
- Shared package aia_pkg holds:
  - csr_op_e enum (READ, SET_PEND, CLR_PEND, SET_EN, CLR_EN);
  - the NR_INTP_FILES / NR_SOURCES defaults taken from the core config package constants;
  - the file-index localparams M_FILE=0, S_FILE=1, VS_FILE_BASE=2.
- One sub-module, aia_top_prio_enc: a parameterised lowest-set-index encoder (NR_SOURCES bits in, identity out, bit 0 ignored). It is instantiated once per file.

Test Plan:
- Reset, then enable id 5 in file 1 via CSR SET_EN, then MSI file 1 id 5 -> topid file1 = 5 and eip_o[1] = 1 one cycle after the MSI grant; other files stay 0.
- MSI ids 7 and 3 to file 0 with both enabled, then a claim on file 0 -> claim_id_o = 3; topid_o file0 = 7 one cycle after the claim edge; a second claim returns 7; a third claim returns 0 and eip_o[0] = 0.
- CSR, claim and MSI all valid together -> claim granted; CSR next cycle; MSI third. Only one ready per cycle.
- CSR held valid continuously with MSI valid -> MSI granted after exactly 4 stalled cycles (starve_cnt = 4); starve_cnt then clears.
- Invalid requests: MSI with id 0, id 30 or file 3 -> accepted and no state change. CSR READ of file 3 -> csr_rdata_o = 0. csr_op_i = 6 -> behaves as READ.
- Assert rst_i while a CSR response is pending, with pending bits set -> next cycle csr_rvalid_o = 0, all topid_o and eip_o = 0, and all readies 0 while reset is high.
